// File: rtl/ps2_game_input.sv
// PS/2 set-2 scancode decoder for the game: turns make/break codes into
// held-key flags and registered move/fire/pause controls with a fire cooldown.
module ps2_game_input #(
  parameter int unsigned FIRE_COOLDOWN = 2500000
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  output logic       move_left,
  output logic       move_right,
  output logic       fire,
  output logic       pause
);

  localparam logic [7:0]  CODE_EXT   = 8'hE0;
  localparam logic [7:0]  CODE_BRK   = 8'hF0;
  localparam logic [7:0]  CODE_A     = 8'h1C;
  localparam logic [7:0]  CODE_D     = 8'h23;
  localparam logic [7:0]  CODE_SPACE = 8'h29;
  localparam logic [7:0]  CODE_P     = 8'h4D;
  localparam logic [7:0]  CODE_LARR  = 8'h6B;
  localparam logic [7:0]  CODE_RARR  = 8'h74;
  localparam logic [21:0] CD_RELOAD  = 22'(FIRE_COOLDOWN - 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t      state;
  state_t      state_next;
  logic        norm_make;
  logic        norm_brk;
  logic        ext_make;
  logic        ext_brk;
  logic        held_a;
  logic        held_larrow;
  logic        held_d;
  logic        held_rarrow;
  logic        held_space;
  logic        held_p;
  logic        p_make_q;
  logic        p_brk_q;
  logic        pause_next;
  logic        lreq;
  logic        rreq;
  logic        fire_next;
  logic [21:0] cd;

  // Prefix tracker state register; a reset drops any pending E0/F0 prefix.
  always_ff @(posedge vga_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: only strobed bytes move the prefix tracker.
  always_comb begin
    state_next = state;
    if (ps2_key_pressed) begin
      case (state)
        IDLE: begin
          if (ps2_key_data == CODE_EXT)      state_next = EXT;
          else if (ps2_key_data == CODE_BRK) state_next = BRK;
          else                               state_next = IDLE;
        end
        EXT: begin
          if (ps2_key_data == CODE_BRK)      state_next = EXT_BRK;
          else if (ps2_key_data == CODE_EXT) state_next = EXT;
          else                               state_next = IDLE;
        end
        BRK:     state_next = IDLE;
        EXT_BRK: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Decoded key events for the byte that completes a make or break sequence.
  always_comb begin
    norm_make = 1'b0;
    norm_brk  = 1'b0;
    ext_make  = 1'b0;
    ext_brk   = 1'b0;
    if (ps2_key_pressed) begin
      case (state)
        IDLE:    norm_make = (ps2_key_data != CODE_EXT) && (ps2_key_data != CODE_BRK);
        EXT:     ext_make  = (ps2_key_data != CODE_EXT) && (ps2_key_data != CODE_BRK);
        BRK:     norm_brk  = (ps2_key_data != CODE_EXT);
        EXT_BRK: ext_brk   = 1'b1;
        default: ;
      endcase
    end
  end

  // Held-key flags track make/break on the consuming edge; P events are staged one cycle.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      held_a      <= 1'b0;
      held_larrow <= 1'b0;
      held_d      <= 1'b0;
      held_rarrow <= 1'b0;
      held_space  <= 1'b0;
      p_make_q    <= 1'b0;
      p_brk_q     <= 1'b0;
    end else begin
      if (norm_make && ps2_key_data == CODE_A)          held_a <= 1'b1;
      else if (norm_brk && ps2_key_data == CODE_A)      held_a <= 1'b0;
      if (ext_make && ps2_key_data == CODE_LARR)        held_larrow <= 1'b1;
      else if (ext_brk && ps2_key_data == CODE_LARR)    held_larrow <= 1'b0;
      if (norm_make && ps2_key_data == CODE_D)          held_d <= 1'b1;
      else if (norm_brk && ps2_key_data == CODE_D)      held_d <= 1'b0;
      if (ext_make && ps2_key_data == CODE_RARR)        held_rarrow <= 1'b1;
      else if (ext_brk && ps2_key_data == CODE_RARR)    held_rarrow <= 1'b0;
      if (norm_make && ps2_key_data == CODE_SPACE)      held_space <= 1'b1;
      else if (norm_brk && ps2_key_data == CODE_SPACE)  held_space <= 1'b0;
      p_make_q <= norm_make && (ps2_key_data == CODE_P);
      p_brk_q  <= norm_brk && (ps2_key_data == CODE_P);
    end
  end

  // Control terms for the output stage; move and fire are gated by the pause value being registered.
  always_comb begin
    pause_next = pause ^ (p_make_q & ~held_p);
    lreq       = held_a | held_larrow;
    rreq       = held_d | held_rarrow;
    fire_next  = held_space & (cd == 22'd0) & ~pause_next;
  end

  // Registered outputs, P edge-detect and fire cooldown counter.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      held_p     <= 1'b0;
      pause      <= 1'b0;
      move_left  <= 1'b0;
      move_right <= 1'b0;
      fire       <= 1'b0;
      cd         <= 22'd0;
    end else begin
      pause      <= pause_next;
      if (p_make_q)     held_p <= 1'b1;
      else if (p_brk_q) held_p <= 1'b0;
      move_left  <= lreq & ~rreq & ~pause_next;
      move_right <= rreq & ~lreq & ~pause_next;
      fire       <= fire_next;
      if (fire_next)          cd <= CD_RELOAD;
      else if (cd != 22'd0)   cd <= cd - 22'd1;
    end
  end

endmodule

// File: tb/tb_ps2_game_input.sv
// Directed bench for ps2_game_input: each step drives one cycle of input,
// queues the hand-derived output vector {move_left, move_right, fire, pause}
// expected right after that edge, and compares it once the edge has passed.
module tb_ps2_game_input;

  logic       vga_clk;
  logic       reset;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed;
  logic       move_left;
  logic       move_right;
  logic       fire;
  logic       pause;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [3:0] exp;
  } exp_t;

  exp_t sb[$];

  ps2_game_input #(.FIRE_COOLDOWN(4)) dut (
    .vga_clk        (vga_clk),
    .reset          (reset),
    .ps2_key_data   (ps2_key_data),
    .ps2_key_pressed(ps2_key_pressed),
    .move_left      (move_left),
    .move_right     (move_right),
    .fire           (fire),
    .pause          (pause)
  );

  // Free-running 100 MHz clock.
  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // Pops the oldest expectation and compares it with the DUT outputs.
  task checkOutput();
    exp_t       item;
    logic [3:0] obs;
    obs = {move_left, move_right, fire, pause};
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("[TB] FAIL scoreboard_empty observed=%b", obs);
    end else begin
      item = sb.pop_front();
      assert (obs === item.exp) else begin
        failures++;
        $error("[TB] FAIL %s observed=%b expected=%b", item.tag, obs, item.exp);
      end
    end
  endtask

  // Drives one cycle of input, queues its expected outputs, then checks after the edge.
  task applyStimulus(input logic rst, input logic pr, input logic [7:0] d,
                     input logic [3:0] e, input string tag);
    exp_t item;
    reset           = rst;
    ps2_key_pressed = pr;
    ps2_key_data    = d;
    item.tag = tag;
    item.exp = e;
    sb.push_back(item);
    @(posedge vga_clk);
    #1;
    checkOutput();
  endtask

  task key(input logic [7:0] d, input logic [3:0] e, input string tag);
    applyStimulus(1'b0, 1'b1, d, e, tag);
  endtask

  task idle(input logic [3:0] e, input string tag);
    applyStimulus(1'b0, 1'b0, 8'h00, e, tag);
  endtask

  initial begin
    reset           = 1'b1;
    ps2_key_pressed = 1'b0;
    ps2_key_data    = 8'h00;

    // Reset with a space byte strobed: the byte must be ignored.
    applyStimulus(1'b1, 1'b1, 8'h29, 4'b0000, "reset0");
    applyStimulus(1'b1, 1'b1, 8'h29, 4'b0000, "reset1");
    idle(4'b0000, "post_reset0");
    idle(4'b0000, "post_reset1");
    idle(4'b0000, "post_reset2");

    // A make, idle, A break.
    key(8'h1C, 4'b0000, "a_make");
    idle(4'b1000, "a_left1");
    idle(4'b1000, "a_left2");
    key(8'hF0, 4'b1000, "a_f0");
    key(8'h1C, 4'b1000, "a_brk");
    idle(4'b0000, "a_released");

    // Left arrow, then D: conflicting directions cancel.
    key(8'hE0, 4'b0000, "larr_e0");
    key(8'h6B, 4'b0000, "larr_make");
    idle(4'b1000, "larr_left");
    key(8'h23, 4'b1000, "d_make");
    idle(4'b0000, "both_held");
    key(8'hE0, 4'b0000, "larr_brk_e0");
    key(8'hF0, 4'b0000, "larr_brk_f0");
    key(8'h6B, 4'b0000, "larr_brk");
    idle(4'b0100, "d_right");
    key(8'hF0, 4'b0100, "d_f0");
    key(8'h23, 4'b0100, "d_brk");
    idle(4'b0000, "d_released");

    // Repeated E0 prefix still yields an extended make.
    key(8'hE0, 4'b0000, "ee_e0a");
    key(8'hE0, 4'b0000, "ee_e0b");
    key(8'h6B, 4'b0000, "ee_make");
    idle(4'b1000, "ee_left");
    key(8'hE0, 4'b1000, "ee_brk_e0");
    key(8'hF0, 4'b1000, "ee_brk_f0");
    key(8'h6B, 4'b1000, "ee_brk");
    idle(4'b0000, "ee_released");

    // Space held with cooldown 4: pulses every 4 cycles, break at steps 21/22.
    key(8'h29, 4'b0000, "space_make");
    for (int i = 1; i <= 22; i++) begin
      logic [3:0] e;
      e = {2'b00, ((i - 1) % 4 == 0), 1'b0};
      if (i == 21)      key(8'hF0, e, $sformatf("fire_f0_%0d", i));
      else if (i == 22) key(8'h29, e, $sformatf("fire_brk_%0d", i));
      else              idle(e, $sformatf("fire_hold_%0d", i));
    end
    // Quick re-press must wait out the running cooldown.
    key(8'h29, 4'b0000, "repress_make");
    idle(4'b0000, "repress_cd");
    idle(4'b0010, "repress_fire");
    key(8'hF0, 4'b0000, "repress_f0");
    key(8'h29, 4'b0000, "repress_brk");
    for (int i = 0; i < 6; i++) idle(4'b0000, $sformatf("space_released_%0d", i));

    // Pause with typematic P, while A and space are held.
    key(8'h1C, 4'b0000, "p_a_make");
    idle(4'b1000, "p_a_left");
    key(8'h4D, 4'b1000, "p_make1");
    key(8'h4D, 4'b0001, "p_make2");
    key(8'h4D, 4'b0001, "p_make3");
    idle(4'b0001, "p_hold");
    key(8'hF0, 4'b0001, "p_f0");
    key(8'h4D, 4'b0001, "p_brk");
    idle(4'b0001, "p_released");
    key(8'h29, 4'b0001, "p_space_make");
    idle(4'b0001, "p_no_fire1");
    idle(4'b0001, "p_no_fire2");
    key(8'h4D, 4'b0001, "p_make_again");
    idle(4'b1010, "p_unpaused_fire");
    idle(4'b1000, "p_unpaused");
    key(8'hF0, 4'b1000, "p_space_f0");
    key(8'h29, 4'b1000, "p_space_brk");
    idle(4'b1000, "p_space_gone");
    key(8'hF0, 4'b1000, "p_brk2_f0");
    key(8'h4D, 4'b1000, "p_brk2");
    idle(4'b1000, "p_brk2_idle");
    key(8'hF0, 4'b1000, "p_a_f0");
    key(8'h1C, 4'b1000, "p_a_brk");
    idle(4'b0000, "p_a_released");

    // Reset mid-sequence clears held flags and the E0 prefix.
    key(8'h1C, 4'b0000, "rst_a_make");
    idle(4'b1000, "rst_a_left");
    key(8'hE0, 4'b1000, "rst_e0");
    applyStimulus(1'b1, 1'b0, 8'h00, 4'b0000, "rst_mid");
    key(8'h6B, 4'b0000, "rst_6b_normal");
    idle(4'b0000, "rst_idle1");
    idle(4'b0000, "rst_idle2");

    // F0 E0 74: E0 discarded, 74 taken as an unmapped normal make.
    key(8'hF0, 4'b0000, "mal_f0");
    key(8'hE0, 4'b0000, "mal_e0");
    key(8'h74, 4'b0000, "mal_74");
    idle(4'b0000, "mal_idle1");
    idle(4'b0000, "mal_idle2");
    key(8'h1C, 4'b0000, "mal_a_make");
    idle(4'b1000, "mal_a_left");
    key(8'hF0, 4'b1000, "mal_a_f0");
    key(8'h1C, 4'b1000, "mal_a_brk");
    idle(4'b0000, "mal_a_released");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
